instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Encodes field-level instruction requests into 32-bit MIPS words for the six classes the main
//  decoder recognises: R-type, LW, SW, BEQ, ADDI and J.
//  Buffers the encoded words in a small FIFO and writes them to instruction memory at
//  consecutive word addresses.
//  It is the program loader / stimulus writer on the instruction side. The decoder's opcodes are
//  produced here.
// PARAMETERS
//  AW     32  imem byte-address width
//  DEPTH  4   FIFO entries, power of two, >=2
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  in_valid   in   1   request valid
//  in_ready   out  1   request accepted when in_valid&in_ready
//  in_kind    in   3   0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6-7 illegal
//  in_rs      in   5   rs field
//  in_rt      in   5   rt field
//  in_rd      in   5   rd field (RTYPE only)
//  in_shamt   in   5   shamt field (RTYPE only)
//  in_funct   in   6   funct field (RTYPE only)
//  in_imm     in   16  immediate (LW/SW/BEQ/ADDI)
//  in_target  in   26  jump target (J)
//  load_base  in   1   load write address from base_addr
//  base_addr  in   AW  new byte address; bits[1:0] ignored (forced 0)
//  imem_we    out  1   write request
//  imem_ready in   1   memory accepts write when imem_we&imem_ready
//  imem_addr  out  AW  byte address of current write
//  imem_wd    out  32  encoded instruction word
//  err        out  1   sticky: an illegal in_kind was accepted
//  wr_count   out  16  writes completed since reset, wraps at 2^16
// BEHAVIOUR
//  Reset (synchronous, active-high)
//  - All outputs and state clear the cycle after reset is sampled high: FIFO empty, imem_we=0,
//    imem_addr=0, err=0, wr_count=0.
//  - Reset mid-transfer discards all queued words.
//  Encoding (combinational at acceptance; the word is registered into the FIFO)
//  - RTYPE = {6'b000000, rs, rt, rd, shamt, funct}
//  - LW    = {6'b100011, rs, rt, imm}
//  - SW    = {6'b101011, rs, rt, imm}
//  - BEQ   = {6'b000100, rs, rt, imm}
//  - ADDI  = {6'b001000, rs, rt, imm}
//  - J     = {6'b000010, target}
//  - Fields not used by the class are ignored.
//  Input handshake
//  - in_ready = !full. It is not combinationally dependent on imem_ready.
//  - A same-cycle pop does not free a slot for a push while the FIFO is full.
//  - Illegal kind (6-7): the request is consumed (in_ready behaves as above), nothing is enqueued,
//    and err sets to 1. err stays 1 until reset.
//  Output side
//  - imem_we = !empty. imem_wd = FIFO head; imem_addr = address register.
//  - imem_we/wd/addr are held stable while imem_we=1 and imem_ready=0.
//  - On imem_we&imem_ready: pop, imem_addr += 4 (modulo 2^AW, wraps to 0), wr_count += 1.
//  - Latency: a word accepted in cycle N with the FIFO empty drives imem_we=1 in cycle N+1.
//    Throughput is 1 word/cycle with imem_ready held at 1.
//  Simultaneous events
//  - Push and pop in the same cycle (not full, not empty): both occur; occupancy unchanged.
//  - load_base coincident with a completing write: the write uses the old imem_addr;
//    next imem_addr = {base_addr[AW-1:2], 2'b00}. load_base has priority over the +4.
//  - load_base with no write: next imem_addr = aligned base_addr; the FIFO is untouched.
//  - FIFO pointers wrap modulo DEPTH. Full/empty are tracked with a count or an extra pointer bit.
// STRUCTURE
//  - Shared package mips_pkg: 6-bit opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
//    and the 3-bit in_kind codes. This block and the decoder both use these.
//  - Sub-module sync_fifo #(WIDTH=32, DEPTH): sync reset, push/pop, full/empty, head output.
//  - The encoder is a combinational case on in_kind inside this module.
// TESTING
//  - ADDI rs=0 rt=8 imm=5, imem_ready=1 -> next cycle imem_we=1, wd=0x20080005, addr=0x0;
//    after the write, addr=0x4 and wr_count=1.
//  - Back-to-back LW rs8 rt9 imm4, SW rs8 rt9 imm8, BEQ rs8 rt9 imm=0xFFFF,
//    RTYPE rs8 rt9 rd10 shamt0 funct0x20, J target 0x10 -> wd sequence 0x8D090004, 0xAD090008,
//    0x1109FFFF, 0x01095020, 0x08000010 at addr 0x0,0x4,0x8,0xC,0x10; 1/cycle.
//  - Backpressure: hold imem_ready=0 and push 5 legal requests with DEPTH=4 -> in_ready drops
//    after the 4th accept. wd/addr are stable throughout the stall. Release imem_ready -> 4 writes
//    in order, then in_ready=1.
//  - in_kind=6 with in_valid=1 -> request consumed, no imem_we, err=1. err persists after further
//    legal requests until reset.
//  - load_base base_addr=0x00400003 in the same cycle as a completing write at 0x8 -> that write
//    goes to 0x8; the next write goes to 0x00400000.
//  - Wrap and reset: AW=8, load_base base_addr=0xFC, two writes -> addresses 0xFC then 0x00.
//    Assert reset with 3 queued words -> next cycle imem_we=0, addr=0, wr_count=0, err=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Opcode constants and request-kind codes shared by the instruction encoder and the main decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Codes 6 and 7 are deliberately left unnamed: they are the illegal kinds.
    typedef enum logic [2:0] {
        KIND_RTYPE = 3'd0,
        KIND_LW    = 3'd1,
        KIND_SW    = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ADDI  = 3'd4,
        KIND_J     = 3'd5
    } kind_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Request bus into the encoder and write bus out to instruction memory.
// Both directions use valid/ready: a beat transfers in the cycle where valid and ready are both 1;
// a source keeps its payload stable while valid=1 and ready=0.
interface instr_encoder_if #(parameter int AW = 32);

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_kind;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [4:0]    in_shamt;
    logic [5:0]    in_funct;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          load_base;
    logic [AW-1:0] base_addr;
    logic          imem_we;
    logic          imem_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
        output load_base, base_addr, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wd
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
        input  load_base, base_addr, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wd
    );

endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Single-clock FIFO with a synchronous reset; occupancy is tracked with a count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             wr_en;
    logic             rd_en;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field-level requests into MIPS instruction words, queues them, and writes them to
// instruction memory at consecutive word addresses.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    instr_encoder_if.slave bus,
    output logic          err,
    output logic [15:0]   wr_count
);

    logic [31:0]   enc_word;
    logic          legal;
    logic [31:0]   head;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic [AW-1:0] addr;

    always_comb begin
        enc_word = '0;
        legal    = 1'b1;
        case (bus.in_kind)
            KIND_RTYPE: enc_word = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
            KIND_LW:    enc_word = {OP_LW,   bus.in_rs, bus.in_rt, bus.in_imm};
            KIND_SW:    enc_word = {OP_SW,   bus.in_rs, bus.in_rt, bus.in_imm};
            KIND_BEQ:   enc_word = {OP_BEQ,  bus.in_rs, bus.in_rt, bus.in_imm};
            KIND_ADDI:  enc_word = {OP_ADDI, bus.in_rs, bus.in_rt, bus.in_imm};
            KIND_J:     enc_word = {OP_J,    bus.in_target};
            default:    legal    = 1'b0;
        endcase
    end

    // Illegal requests are still consumed so the requester never stalls on them.
    assign accept = bus.in_valid && !full;
    assign push   = accept && legal;
    assign pop    = !empty && bus.imem_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (enc_word),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready  = !full;
    assign bus.imem_we   = !empty;
    assign bus.imem_wd   = head;
    assign bus.imem_addr = addr;

    // A base load wins over the post-write increment; the completing write already used the old address.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr     <= '0;
            err      <= 1'b0;
            wr_count <= '0;
        end else begin
            if (bus.load_base) begin
                addr <= bus.base_addr & ~AW'(3);
            end else if (pop) begin
                addr <= addr + AW'(4);
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
            if (pop) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule
